// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter in front of a single-cycle memory with
// separate read and write ports.
//   m0 : instruction-fetch master, read only
//   m1 : loader/debug master, read or write
// Grants are combinational from the requests and the registered arbiter
// state. Read data comes back exactly one cycle after the read grant and is
// steered to the master that issued the read.
//
// Build option:
//   MEM_ARB_FETCH_PRIO_EN  defined   -> m0 has fixed priority. m1 is protected
//                                       from starvation: after STARVE_LIM lost
//                                       contests in a row, m1 wins the next one.
//                          undefined -> round-robin between m0 and m1. No
//                                       starve counter is built and STARVE_LIM
//                                       is only range-checked.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,

  // Instruction-fetch master
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_gnt_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_rvalid_o,

  // Loader/debug master
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_rvalid_o,

  // Memory write port
  output logic              mem_w_en_o,
  output logic [ADDR_W-1:0] mem_w_addr_o,
  output logic [DATA_W-1:0] mem_w_data_o,

  // Memory read port
  output logic              mem_r_en_o,
  output logic [ADDR_W-1:0] mem_r_addr_o,
  input  logic [DATA_W-1:0] mem_r_data_i
);

  // Identifies which master last won, or which master owns the in-flight read.
  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  // The starve counter is four bits wide, so the limit must fit in 1..15.
  if ((STARVE_LIM < 1) || (STARVE_LIM > 15)) begin : g_bad_starve_lim
    $error("mem_port_arbiter: STARVE_LIM must be in the range 1..15");
  end

  owner_t last_gnt;    // most recent winner; it loses the next contest in RR mode
  logic   tag_valid;   // a read was granted last cycle and its data returns now
  owner_t tag_owner;   // master that receives the returning read data
  logic   gnt0;
  logic   gnt1;
  logic   m1_read_gnt;
  logic   both_req;

  assign both_req    = m0_req_i & m1_req_i;
  assign m1_read_gnt = gnt1 & ~m1_we_i;

`ifdef MEM_ARB_FETCH_PRIO_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] starve_cnt;
  logic       starve_hit;

  // Once m1 has lost LIM contests in a row, it wins the next one.
  assign starve_hit = (starve_cnt >= LIM);

  // Count the cycles m1 waits. Clear the count when m1 is served or stops
  // asking, and hold it at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!m1_req_i || gnt1) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Pick the winner for this cycle. A lone requester wins at once. Contention
  // is settled by the build option. Reset suppresses every grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (both_req) begin
`ifdef MEM_ARB_FETCH_PRIO_EN
        if (starve_hit) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`else
        if (last_gnt == OWNER_M0) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`endif
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Route the winning request onto the memory ports in the same cycle.
  // Idle ports are held at zero so unused buses do not toggle.
  always_comb begin
    mem_w_en_o   = 1'b0;
    mem_w_addr_o = '0;
    mem_w_data_o = '0;
    mem_r_en_o   = 1'b0;
    mem_r_addr_o = '0;
    if (gnt0) begin
      mem_r_en_o   = 1'b1;
      mem_r_addr_o = m0_addr_i;
    end else if (gnt1) begin
      if (m1_we_i) begin
        mem_w_en_o   = 1'b1;
        mem_w_addr_o = m1_addr_i;
        mem_w_data_o = m1_wdata_i;
      end else begin
        mem_r_en_o   = 1'b1;
        mem_r_addr_o = m1_addr_i;
      end
    end
  end

  // Record the winner of each grant. After reset, m1 counts as the last
  // winner so the first contest goes to m0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= OWNER_M1;
    end else if (gnt0) begin
      last_gnt <= OWNER_M0;
    end else if (gnt1) begin
      last_gnt <= OWNER_M1;
    end
  end

  // Tag the read that returns next cycle with its owner. Writes leave no tag.
  // Reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_owner <= OWNER_M0;
    end else begin
      tag_valid <= gnt0 | m1_read_gnt;
      tag_owner <= gnt1 ? OWNER_M1 : OWNER_M0;
    end
  end

  // Send the returning read data only to its owner. The other master sees
  // zeros, and nothing is returned while reset is asserted.
  always_comb begin
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    if (!rst && tag_valid) begin
      if (tag_owner == OWNER_M0) begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = mem_r_data_i;
      end else begin
        m1_rvalid_o = 1'b1;
        m1_rdata_o  = mem_r_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. The bench provides a small memory. A
// behavioural model of the arbitration rules is checked against the DUT on
// every cycle, and directed scenarios pin the model with hand-computed
// values. Works with or without MEM_ARB_FETCH_PRIO_EN.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic          m1_req = 1'b0;
  logic          m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] mem_r_data = '0;

  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_w_en, mem_r_en;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic [DW-1:0] mem_w_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt),
    .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .mem_w_en_o(mem_w_en), .mem_w_addr_o(mem_w_addr), .mem_w_data_o(mem_w_data),
    .mem_r_en_o(mem_r_en), .mem_r_addr_o(mem_r_addr), .mem_r_data_i(mem_r_data)
  );

  // Bench memory. Addresses never written read back as addr ^ 0x5A5A0000.
  logic [DW-1:0] mem_arr [logic [AW-1:0]];

  function automatic logic [DW-1:0] memVal(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (mem_w_en) mem_arr[mem_w_addr] = mem_w_data;
    if (mem_r_en) mem_r_data <= memVal(mem_r_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model state: pending read response, last winner (0/1), and m1 wait count.
  bit            pend_valid = 1'b0;
  int            pend_owner = 0;
  logic [DW-1:0] pend_data  = '0;
  int            last_win   = 1;
  int            starve     = 0;

  // Compare the DUT with the model in the middle of every cycle, then advance
  // the model to what the next rising edge must leave behind.
  always @(negedge clk) begin
    int win;
    logic [AW-1:0] e_raddr, e_waddr;
    logic [DW-1:0] e_wdata;
    bit e_ren, e_wen;
    win = -1; e_ren = 0; e_wen = 0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
    if (!rst) begin
      if (m0_req && m1_req) begin
`ifdef MEM_ARB_FETCH_PRIO_EN
        win = (starve >= LIM) ? 1 : 0;
`else
        win = (last_win == 0) ? 1 : 0;
`endif
      end else if (m0_req) win = 0;
      else if (m1_req) win = 1;
    end
    if (win == 0) begin e_ren = 1; e_raddr = m0_addr; end
    if (win == 1 && !m1_we) begin e_ren = 1; e_raddr = m1_addr; end
    if (win == 1 && m1_we) begin e_wen = 1; e_waddr = m1_addr; e_wdata = m1_wdata; end

    checkOutput("m0_gnt", 32'(m0_gnt), 32'(win == 0));
    checkOutput("m1_gnt", 32'(m1_gnt), 32'(win == 1));
    checkOutput("mem_r_en", 32'(mem_r_en), 32'(e_ren));
    checkOutput("mem_r_addr", mem_r_addr, e_raddr);
    checkOutput("mem_w_en", 32'(mem_w_en), 32'(e_wen));
    checkOutput("mem_w_addr", mem_w_addr, e_waddr);
    checkOutput("mem_w_data", mem_w_data, e_wdata);
    checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(!rst && pend_valid && pend_owner == 0));
    checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(!rst && pend_valid && pend_owner == 1));
    checkOutput("m0_rdata", m0_rdata, (!rst && pend_valid && pend_owner == 0) ? pend_data : 32'h0);
    checkOutput("m1_rdata", m1_rdata, (!rst && pend_valid && pend_owner == 1) ? pend_data : 32'h0);

    if (rst) begin
      pend_valid = 0; last_win = 1; starve = 0;
    end else begin
      pend_valid = e_ren;
      pend_owner = win;
      pend_data  = memVal(e_raddr);
      if (win >= 0) last_win = win;
      if (!m1_req || win == 1) starve = 0;
      else if (starve < LIM) starve = starve + 1;
    end
  end

  // Drive one cycle of inputs just after the rising edge, then wait until
  // mid-cycle so the caller can sample outputs.
  task automatic applyStimulus(input logic r, input logic r0, input logic [AW-1:0] a0,
                               input logic r1, input logic we, input logic [AW-1:0] a1,
                               input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    rst = r; m0_req = r0; m0_addr = a0;
    m1_req = r1; m1_we = we; m1_addr = a1; m1_wdata = wd;
    @(negedge clk);
  endtask

  int exp_win[6];

  initial begin
`ifdef MEM_ARB_FETCH_PRIO_EN
    exp_win = '{0, 0, 0, 0, 1, 0};
`else
    exp_win = '{0, 1, 0, 1, 0, 1};
`endif
    // Reset: requests present but nothing may be granted.
    applyStimulus(1, 1, 32'h40, 1, 0, 32'h44, 0);
    checkOutput("reset_m0_gnt", 32'(m0_gnt), 0);
    checkOutput("reset_mem_r_en", 32'(mem_r_en), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Single fetch at address 0.
    applyStimulus(0, 1, 32'h0, 0, 0, 0, 0);
    checkOutput("fetch0_gnt", 32'(m0_gnt), 1);
    checkOutput("fetch0_raddr", mem_r_addr, 32'h0);
    checkOutput("fetch0_m1_gnt", 32'(m1_gnt), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch0_rvalid", 32'(m0_rvalid), 1);
    checkOutput("fetch0_rdata", m0_rdata, 32'h5A5A0000);
    checkOutput("fetch0_m1_rdata", m1_rdata, 32'h0);

    // Loader write, then read back from the same address.
    applyStimulus(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    checkOutput("wr_w_en", 32'(mem_w_en), 1);
    checkOutput("wr_w_addr", mem_w_addr, 32'h10);
    checkOutput("wr_w_data", mem_w_data, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 1, 0, 32'h10, 0);
    checkOutput("wr_no_rvalid", 32'(m1_rvalid), 0);
    checkOutput("rd_r_en", 32'(mem_r_en), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd_rvalid", 32'(m1_rvalid), 1);
    checkOutput("rd_rdata", m1_rdata, 32'hDEADBEEF);

    // Both masters requesting for six cycles.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 32'h100, 1, 0, 32'h200, 0);
      checkOutput("contest_m0_gnt", 32'(m0_gnt), 32'(exp_win[i] == 0));
      checkOutput("contest_m1_gnt", 32'(m1_gnt), 32'(exp_win[i] == 1));
      if (i > 0) begin
        checkOutput("contest_m0_rvalid", 32'(m0_rvalid), 32'(exp_win[i-1] == 0));
        checkOutput("contest_m1_rvalid", 32'(m1_rvalid), 32'(exp_win[i-1] == 1));
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("contest_last_m1_rvalid", 32'(m1_rvalid), 32'(exp_win[5] == 1));

    // m1 read immediately followed by an m0 read.
    applyStimulus(0, 0, 0, 1, 0, 32'h20, 0);
    checkOutput("seq_m1_gnt", 32'(m1_gnt), 1);
    applyStimulus(0, 1, 32'h24, 0, 0, 0, 0);
    checkOutput("seq_m1_rvalid", 32'(m1_rvalid), 1);
    checkOutput("seq_m1_rdata", m1_rdata, 32'h5A5A0020);
    checkOutput("seq_m0_rvalid_quiet", 32'(m0_rvalid), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq_m0_rvalid", 32'(m0_rvalid), 1);
    checkOutput("seq_m0_rdata", m0_rdata, 32'h5A5A0024);
    checkOutput("seq_m1_rvalid_quiet", 32'(m1_rvalid), 0);

    // Back-to-back fetches, interrupted by reset.
    applyStimulus(0, 1, 32'h0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h4, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h8, 0, 0, 0, 0);
    checkOutput("b2b_rdata4", m0_rdata, 32'h5A5A0004);
    applyStimulus(1, 1, 32'hC, 1, 0, 32'h30, 0);
    checkOutput("midrst_m0_rvalid", 32'(m0_rvalid), 0);
    checkOutput("midrst_m0_gnt", 32'(m0_gnt), 0);
    checkOutput("midrst_r_en", 32'(mem_r_en), 0);
    applyStimulus(0, 1, 32'hC, 1, 0, 32'h30, 0);
    checkOutput("postrst_m0_gnt", 32'(m0_gnt), 1);
    checkOutput("postrst_m1_gnt", 32'(m1_gnt), 0);
    checkOutput("postrst_no_rvalid", 32'(m0_rvalid), 0);
    applyStimulus(0, 1, 32'h10, 1, 0, 32'h30, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // m1 drops its request partway through, which clears any starvation credit.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h50, 1, 0, 32'h60, 0);
    applyStimulus(0, 1, 32'h50, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 32'h54, 1, 1, 32'h64, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width for all ports.
REQ-002 Parameter DATA_W, 32, data width for all ports.
REQ-003 Parameter STARVE_LIM, 4, consecutive lost-contest cycles of m1 before forced m1 grant (priority mode only); range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 m0_req_i  input  1  instruction-fetch read request.
REQ-007 m0_addr_i  input  ADDR_W  fetch address.
REQ-008 m0_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 m0_rdata_o / m0_rvalid_o  output  DATA_W / 1  fetch read data and its valid strobe.
REQ-010 m1_req_i / m1_we_i  input  1 / 1  loader/debug request; we=1 write, we=0 read.
REQ-011 m1_addr_i / m1_wdata_i  input  ADDR_W / DATA_W  loader address and write data.
REQ-012 m1_gnt_o  output  1  loader request accepted this cycle.
REQ-013 m1_rdata_o / m1_rvalid_o  output  DATA_W / 1  loader read data and valid strobe.
REQ-014 mem_w_en_o, mem_w_addr_o, mem_w_data_o  output  1, ADDR_W, DATA_W  memory write port.
REQ-015 mem_r_en_o, mem_r_addr_o  output  1, ADDR_W  memory read port.
REQ-016 mem_r_data_i  input  DATA_W  memory read data, valid one cycle after mem_r_en_o.

Function
REQ-017 At most one of m0_gnt_o, m1_gnt_o shall be high in any cycle; grant is combinational from req and registered arbiter state.
REQ-018 A granted request shall drive the memory port in the same cycle: m0 -> r_en=1, r_addr=m0_addr; m1 read -> r_en=1, r_addr=m1_addr; m1 write -> w_en=1, w_addr/w_data from m1.
REQ-019 With no grant, all mem_*_en_o shall be 0 and addresses/data 0.
REQ-020 Read latency: rvalid of the granted master shall be high exactly the cycle after its read grant, rdata = mem_r_data_i in that cycle; writes shall produce no rvalid.
REQ-021 Back-to-back grants every cycle shall be supported; response tag register (1 bit owner + 1 bit valid) tracks the in-flight read.
REQ-022 Single requester: granted same cycle, no bubble.
REQ-023 Both requesting, round-robin mode: grant the master not granted most recently (last_gnt register, updated on every grant).
REQ-024 Both requesting, priority mode: m0 wins; m1 starve counter increments each cycle m1 requests and is not granted; when counter reaches STARVE_LIM, m1 is granted next contest and counter clears; counter clears on any m1 grant or m1_req low; saturates at STARVE_LIM.
REQ-025 Requests deasserted without grant shall leave no side effects; requester holds req/addr/data stable until granted.
REQ-026 rdata of the non-owning master shall read 0 and its rvalid 0.

Reset
REQ-027 While rst=1: gnt, rvalid, rdata, mem enables, addresses, data all 0; last_gnt = m1 (first contest goes to m0); starve counter = 0; in-flight read discarded, no rvalid in the cycle after reset releases.
REQ-028 Reset asserted mid-stream shall take effect at the next edge regardless of pending requests.

Configuration
REQ-029 Macro MEM_ARB_FETCH_PRIO_EN: defined -> priority mode with starvation guard (REQ-024); undefined -> round-robin mode (REQ-023), starve counter not instantiated, STARVE_LIM ignored.

Verification
REQ-030 Reset, then m0_req=1 addr=0x0 alone -> m0_gnt same cycle, mem_r_addr=0x0, m0_rvalid next cycle with mem data; m1 outputs 0.
REQ-031 m1 write addr=0x10 data=0xDEADBEEF, then m1 read 0x10 -> w_en pulse with those values, read returns 0xDEADBEEF one cycle after grant, no rvalid for write.
REQ-032 Round-robin build, both req held 6 cycles -> grants m0,m1,m0,m1,m0,m1; rvalids follow owners one cycle later.
REQ-033 MEM_ARB_FETCH_PRIO_EN, STARVE_LIM=4, both req held -> m0 granted 4 cycles, m1 on cycle 5, then m0 again.
REQ-034 Continuous m0 fetches 0x0,0x4,0x8; rst=1 one cycle after grant of 0x8 -> no rvalid for 0x8 after reset, all outputs 0, next contest grants m0.
REQ-035 Single-cycle m1 read then immediate m0 read -> m1_rvalid then m0_rvalid on consecutive cycles, never both high.
